// File: rtl/pico_ctrl_pkg.sv
// Shared types and phase table for the picoMIPS run controller.
// Phase table lists the PC start address and switch-input select per phase.
package pico_ctrl_pkg;

  localparam int PHASE_W    = 3;
  localparam int MAX_PHASES = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_HOLD,
    S_ERR
  } state_t;

  typedef logic [7:0] pc_tbl_t [MAX_PHASES];
  typedef logic [4:0] wr_tbl_t [MAX_PHASES];

  localparam pc_tbl_t PH_PC = '{
    8'd6, 8'd8, 8'd22, 8'd23,
    8'd24, 8'd0, 8'd0, 8'd0
  };

  localparam wr_tbl_t PH_WR = '{
    5'b00100, 5'b00101, 5'd0, 5'd0,
    5'd0, 5'd0, 5'd0, 5'd0
  };

endpackage

// File: rtl/step_event_gen.sv
// Step switch synchroniser and toggle detector.
// PICO_STEP_DEBOUNCE_EN adds a stable-level filter before edge detection.
module step_event_gen
`ifdef PICO_STEP_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic step_sw,
  output logic step_evt
);

  logic s1, s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= step_sw;
      s2 <= s1;
    end
  end

`ifdef PICO_STEP_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          acc;
  logic [CW-1:0] cnt;
  logic          ripe;

  // Accept the new level once it has differed for the full window
  assign ripe     = (cnt == CW'(DEBOUNCE_CYCLES));
  assign step_evt = (s2 != acc) && ripe;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= 1'b0;
      cnt <= '0;
    end else if (s2 == acc) begin
      cnt <= '0;
    end else if (ripe) begin
      acc <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic s3;

  always_ff @(posedge clk) begin
    if (reset) s3 <= 1'b0;
    else       s3 <= s2;
  end

  assign step_evt = s2 ^ s3;
`endif

endmodule

// File: rtl/pico_phase_controller.sv
// Phase sequencer: loads PC, gates core run until halt, selects input reg.
// Step debounce is enabled with PICO_STEP_DEBOUNCE_EN.
module pico_phase_controller
  import pico_ctrl_pkg::*;
#(
  parameter int n       = 8,
  parameter int PCW     = 6,
  parameter int PHASES  = 5,
  parameter int TIMEOUT = 255
`ifdef PICO_STEP_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_CYCLES = 16
`endif
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               step_sw,
  input  logic               cpu_halt,
  output logic               pc_load,
  output logic [PCW-1:0]     pc_start,
  output logic               cpu_run,
  output logic [4:0]         writein,
  output logic [PHASE_W-1:0] phase,
  output logic               busy,
  output logic               timeout_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_TMO = CW'(TIMEOUT - 1);
  localparam logic [PHASE_W-1:0] LAST = PHASE_W'(PHASES - 1);
  // Start address travels over the core data bus, so clip to it
  localparam int LD_W = (PCW < n) ? PCW : n;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               step_evt;
  logic [PCW-1:0]     tbl_pc;
  logic [7:0]         tbl_raw;

  step_event_gen
`ifdef PICO_STEP_DEBOUNCE_EN
  #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  )
`endif
  u_step (
    .clk     (clk),
    .reset   (reset),
    .step_sw (step_sw),
    .step_evt(step_evt)
  );

  assign tbl_raw = PH_PC[phase_q];
  assign tbl_pc  = PCW'(tbl_raw[LD_W-1:0]);
  assign phase   = phase_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    pc_load     = 1'b0;
    pc_start    = '0;
    cpu_run     = 1'b0;
    writein     = '0;
    busy        = 1'b0;
    timeout_err = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (step_evt) state_d = S_LOAD;
      end
      S_LOAD: begin
        pc_load  = 1'b1;
        pc_start = tbl_pc;
        writein  = PH_WR[phase_q];
        busy     = 1'b1;
        cnt_d    = '0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        cpu_run  = 1'b1;
        pc_start = tbl_pc;
        writein  = PH_WR[phase_q];
        busy     = 1'b1;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // Halt has priority over an expiring timeout
        if (cpu_halt)
          state_d = S_HOLD;
        else if (TIMEOUT != 0 && cnt_q == CNT_TMO)
          state_d = S_ERR;
      end
      S_HOLD: begin
        pc_start = tbl_pc;
        cnt_d    = '0;
        if (step_evt) begin
          if (phase_q == LAST) begin
            phase_d = '0;
            state_d = S_IDLE;
          end else begin
            phase_d = phase_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_ERR: begin
        timeout_err = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pico_phase_controller.sv
// Directed + randomized bench for pico_phase_controller.
// Reference expectations come from the phase table and step/run rules.
module tb_pico_phase_controller;

`ifdef PICO_STEP_DEBOUNCE_EN
  localparam int LAT = 19;
`else
  localparam int LAT = 3;
`endif
  localparam int TMO = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       step_sw = 1'b0;
  logic       cpu_halt = 1'b0;
  logic       pc_load;
  logic [5:0] pc_start;
  logic       cpu_run;
  logic [4:0] writein;
  logic [2:0] phase;
  logic       busy;
  logic       timeout_err;

  int compared = 0;
  int mismatched = 0;
  int loads = 0;
  int exp_pc[5] = '{6, 8, 22, 23, 24};
  int exp_wr[5] = '{4, 5, 0, 0, 0};

  pico_phase_controller dut (
    .clk        (clk),
    .reset      (reset),
    .step_sw    (step_sw),
    .cpu_halt   (cpu_halt),
    .pc_load    (pc_load),
    .pc_start   (pc_start),
    .cpu_run    (cpu_run),
    .writein    (writein),
    .phase      (phase),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (pc_load === 1'b1) loads++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic step_load(input string tag, input int p);
    int lat;
    lat = 0;
    step_sw = ~step_sw;
    do begin
      @(negedge clk);
      lat++;
    end while (pc_load !== 1'b1 && lat < 100);
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_pc"}, pc_start, exp_pc[p]);
    chk({tag, "_wr"}, writein, exp_wr[p]);
    chk({tag, "_ph"}, phase, p);
    chk({tag, "_busy"}, busy, 1);
  endtask

  task automatic run(input int halt_after, input int toggle_at,
                     output int rc);
    int guard;
    rc = 0;
    guard = 0;
    @(negedge clk);
    chk("load_pulse", pc_load, 0);
    while (cpu_run === 1'b1 && guard < 400) begin
      rc++;
      guard++;
      if (rc == toggle_at) step_sw = ~step_sw;
      if (rc == halt_after) cpu_halt = 1'b1;
      @(negedge clk);
    end
    cpu_halt = 1'b0;
  endtask

  task automatic hold_chk(input string tag, input int p);
    chk({tag, "_hwr"}, writein, 0);
    chk({tag, "_hbusy"}, busy, 0);
    chk({tag, "_hpc"}, pc_start, exp_pc[p]);
    chk({tag, "_hph"}, phase, p);
  endtask

  task automatic wrap_chk(input string tag);
    int l0;
    l0 = loads;
    step_sw = ~step_sw;
    tick(LAT + 3);
    chk({tag, "_wph"}, phase, 0);
    chk({tag, "_wout"}, {pc_start, cpu_run, writein, busy}, 0);
    chk({tag, "_wload"}, loads - l0, 0);
  endtask

  initial begin
    int rc, h, t, l0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out", {pc_load, pc_start, cpu_run, writein,
                      phase, busy, timeout_err}, 0);
    end
    reset = 1'b0;
    tick(2);
    chk("idle_out", {pc_load, pc_start, cpu_run, writein,
                     phase, busy, timeout_err}, 0);

    for (int p = 0; p < 5; p++) begin
      step_load("seq", p);
      run(10, 0, rc);
      chk("seq_run", rc, 10);
      hold_chk("seq", p);
      tick(2);
    end
    wrap_chk("seq");

    for (int p = 0; p < 5; p++) begin
      tick($urandom_range(0, 6));
      step_load("rnd", p);
      if (p == 1) begin
        t = $urandom_range(1, 4);
        h = t + LAT + $urandom_range(0, 5);
      end else begin
        t = 0;
        h = $urandom_range(3, 20);
      end
      run(h, t, rc);
      chk("rnd_run", rc, h);
      hold_chk("rnd", p);
      if (p == 1) begin
        l0 = loads;
        tick(LAT + 6);
        chk("drop_ph", phase, 1);
        chk("drop_busy", busy, 0);
        chk("drop_load", loads - l0, 0);
      end
    end
    wrap_chk("rnd");

    step_load("tmo", 0);
    run(0, 0, rc);
    chk("tmo_cycles", rc, TMO);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_run", cpu_run, 0);
    l0 = loads;
    step_sw = ~step_sw;
    tick(LAT + 5);
    chk("tmo_sticky", timeout_err, 1);
    chk("tmo_ignore", loads - l0, 0);
    chk("tmo_busy", busy, 0);
    reset = 1'b1;
    step_sw = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("tmo_clear", timeout_err, 0);

    step_load("mid", 0);
    run(8, 0, rc);
    step_load("mid", 1);
    run(8, 0, rc);
    step_load("mid", 2);
    tick(3);
    chk("mid_running", cpu_run, 1);
    reset = 1'b1;
    step_sw = 1'b0;
    @(negedge clk);
    chk("mid_rst", {phase, cpu_run, writein, busy, pc_load}, 0);
    reset = 1'b0;
    tick(2);

`ifdef PICO_STEP_DEBOUNCE_EN
    l0 = loads;
    step_sw = ~step_sw;
    tick(5);
    step_sw = ~step_sw;
    tick(40);
    chk("glitch_load", loads - l0, 0);
    chk("glitch_busy", busy, 0);
    step_load("deb", 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
